// File: rtl/cache_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_bus_arbiter_if
// Bundles every handshake/bus signal between the two cache controllers
// (m0 = I-cache, m1 = D-cache), the arbiter and the system bus (s_*).
//   modport slave  : arbiter view (it serves the cache controllers and
//                    forwards their traffic to the system bus)
//   modport master : environment view (cache controllers + system bus model)
// Signals per master i: readAddr_valid/readAddr/readAddr_ready,
//   readData_valid/readData_ready, writeAddr_valid/writeAddr/writeAddr_ready,
//   writeData_valid/writeData/writeData_ready, writeResp_valid/writeResp_ready.
// Shared to masters: m_readData, m_writeResp_msg.
// System bus: s_readAddr*, s_readData*, s_writeAddr*, s_writeData*,
//   s_writeResp*.
// -----------------------------------------------------------------------------
interface cache_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_readAddr_valid,  m1_readAddr_valid;
  logic [ADDR_W-1:0] m0_readAddr,        m1_readAddr;
  logic              m0_readAddr_ready,  m1_readAddr_ready;
  logic              m0_readData_ready,  m1_readData_ready;
  logic              m0_readData_valid,  m1_readData_valid;
  logic [DATA_W-1:0] m_readData;
  logic              m0_writeAddr_valid, m1_writeAddr_valid;
  logic              m0_writeData_valid, m1_writeData_valid;
  logic [ADDR_W-1:0] m0_writeAddr,       m1_writeAddr;
  logic [DATA_W-1:0] m0_writeData,       m1_writeData;
  logic              m0_writeAddr_ready, m1_writeAddr_ready;
  logic              m0_writeData_ready, m1_writeData_ready;
  logic              m0_writeResp_ready, m1_writeResp_ready;
  logic              m0_writeResp_valid, m1_writeResp_valid;
  logic [DATA_W-1:0] m_writeResp_msg;

  logic              s_readAddr_valid;
  logic [ADDR_W-1:0] s_readAddr;
  logic              s_readAddr_ready;
  logic              s_readData_valid;
  logic [DATA_W-1:0] s_readData;
  logic              s_readData_ready;
  logic              s_writeAddr_valid, s_writeData_valid;
  logic [ADDR_W-1:0] s_writeAddr;
  logic [DATA_W-1:0] s_writeData;
  logic              s_writeAddr_ready, s_writeData_ready;
  logic              s_writeResp_valid;
  logic [DATA_W-1:0] s_writeResp_msg;
  logic              s_writeResp_ready;

  modport slave (
    input  m0_readAddr_valid, m1_readAddr_valid, m0_readAddr, m1_readAddr,
           m0_readData_ready, m1_readData_ready,
           m0_writeAddr_valid, m1_writeAddr_valid, m0_writeData_valid, m1_writeData_valid,
           m0_writeAddr, m1_writeAddr, m0_writeData, m1_writeData,
           m0_writeResp_ready, m1_writeResp_ready,
           s_readAddr_ready, s_readData_valid, s_readData,
           s_writeAddr_ready, s_writeData_ready, s_writeResp_valid, s_writeResp_msg,
    output m0_readAddr_ready, m1_readAddr_ready, m0_readData_valid, m1_readData_valid,
           m_readData, m0_writeAddr_ready, m1_writeAddr_ready,
           m0_writeData_ready, m1_writeData_ready, m0_writeResp_valid, m1_writeResp_valid,
           m_writeResp_msg, s_readAddr_valid, s_readAddr, s_readData_ready,
           s_writeAddr_valid, s_writeData_valid, s_writeAddr, s_writeData, s_writeResp_ready
  );

  modport master (
    output m0_readAddr_valid, m1_readAddr_valid, m0_readAddr, m1_readAddr,
           m0_readData_ready, m1_readData_ready,
           m0_writeAddr_valid, m1_writeAddr_valid, m0_writeData_valid, m1_writeData_valid,
           m0_writeAddr, m1_writeAddr, m0_writeData, m1_writeData,
           m0_writeResp_ready, m1_writeResp_ready,
           s_readAddr_ready, s_readData_valid, s_readData,
           s_writeAddr_ready, s_writeData_ready, s_writeResp_valid, s_writeResp_msg,
    input  m0_readAddr_ready, m1_readAddr_ready, m0_readData_valid, m1_readData_valid,
           m_readData, m0_writeAddr_ready, m1_writeAddr_ready,
           m0_writeData_ready, m1_writeData_ready, m0_writeResp_valid, m1_writeResp_valid,
           m_writeResp_msg, s_readAddr_valid, s_readAddr, s_readData_ready,
           s_writeAddr_valid, s_writeData_valid, s_writeAddr, s_writeData, s_writeResp_ready
  );
endinterface

// File: rtl/cache_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cache_bus_arbiter
// Shares one system bus between the I-cache (m0) and D-cache (m1) controllers.
// One transaction is in flight at a time; owner selection is round-robin,
// reads win over writes for the same master.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : cache_bus_arbiter_if.slave, all master and system bus handshakes
//   grant_id : registered index of the current/last owner
//   busy     : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module cache_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_bus_arbiter_if.slave    bus,
  output logic                  grant_id,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  state_t state_r;
  logic   grant_r;
  logic   last_owner_r;
  logic   busy_r;

  logic req_rd0_s, req_wr0_s, req_rd1_s, req_wr1_s, req0_s, req1_s;
  logic win_s, win_rd_s;
  logic own_rav_s, own_rdr_s, own_awv_s, own_wdv_s, own_bready_s;
  logic [ADDR_W-1:0] own_raddr_s, own_waddr_s;
  logic [DATA_W-1:0] own_wdata_s;
  logic in_rd_addr_s, in_rd_data_s, in_wr_addr_s, in_wr_resp_s;

  assign req_rd0_s = bus.m0_readAddr_valid;
  assign req_rd1_s = bus.m1_readAddr_valid;
  assign req_wr0_s = bus.m0_writeAddr_valid & bus.m0_writeData_valid;
  assign req_wr1_s = bus.m1_writeAddr_valid & bus.m1_writeData_valid;
  assign req0_s    = req_rd0_s | req_wr0_s;
  assign req1_s    = req_rd1_s | req_wr1_s;

  // On contention the master that was not served last wins.
  assign win_s    = (req0_s & req1_s) ? ~last_owner_r : req1_s;
  assign win_rd_s = win_s ? req_rd1_s : req_rd0_s;

  // Owner-side views of the master signals.
  assign own_rav_s    = grant_r ? bus.m1_readAddr_valid  : bus.m0_readAddr_valid;
  assign own_rdr_s    = grant_r ? bus.m1_readData_ready  : bus.m0_readData_ready;
  assign own_awv_s    = grant_r ? bus.m1_writeAddr_valid : bus.m0_writeAddr_valid;
  assign own_wdv_s    = grant_r ? bus.m1_writeData_valid : bus.m0_writeData_valid;
  assign own_bready_s = grant_r ? bus.m1_writeResp_ready : bus.m0_writeResp_ready;
  assign own_raddr_s  = grant_r ? bus.m1_readAddr        : bus.m0_readAddr;
  assign own_waddr_s  = grant_r ? bus.m1_writeAddr       : bus.m0_writeAddr;
  assign own_wdata_s  = grant_r ? bus.m1_writeData       : bus.m0_writeData;

  assign in_rd_addr_s = (state_r == S_RD_ADDR);
  assign in_rd_data_s = (state_r == S_RD_DATA);
  assign in_wr_addr_s = (state_r == S_WR_ADDR);
  assign in_wr_resp_s = (state_r == S_WR_RESP);

  // Arbitration FSM: owner, direction and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      grant_r      <= 1'b0;
      last_owner_r <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req0_s | req1_s) begin
            grant_r <= win_s;
            busy_r  <= 1'b1;
            state_r <= win_rd_s ? S_RD_ADDR : S_WR_ADDR;
          end
        end
        S_RD_ADDR: begin
          if (own_rav_s & bus.s_readAddr_ready) begin
            state_r <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (bus.s_readData_valid & own_rdr_s) begin
            state_r      <= S_IDLE;
            last_owner_r <= grant_r;
            busy_r       <= 1'b0;
          end
        end
        S_WR_ADDR: begin
          // Address and data must be accepted in the same cycle.
          if (own_awv_s & own_wdv_s & bus.s_writeAddr_ready & bus.s_writeData_ready) begin
            state_r <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bus.s_writeResp_valid & own_bready_s) begin
            state_r      <= S_IDLE;
            last_owner_r <= grant_r;
            busy_r       <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_id = grant_r;
  assign busy     = busy_r;

  // System bus side: valids/readies only in their matching state.
  assign bus.s_readAddr_valid  = in_rd_addr_s & own_rav_s;
  assign bus.s_readAddr        = own_raddr_s;
  assign bus.s_readData_ready  = in_rd_data_s & own_rdr_s;
  assign bus.s_writeAddr_valid = in_wr_addr_s & own_awv_s;
  assign bus.s_writeData_valid = in_wr_addr_s & own_wdv_s;
  assign bus.s_writeAddr       = own_waddr_s;
  assign bus.s_writeData       = own_wdata_s;
  assign bus.s_writeResp_ready = in_wr_resp_s & own_bready_s;

  // Master side: only the owner ever sees a ready/valid.
  assign bus.m0_readAddr_ready  = in_rd_addr_s & ~grant_r & bus.s_readAddr_ready;
  assign bus.m1_readAddr_ready  = in_rd_addr_s &  grant_r & bus.s_readAddr_ready;
  assign bus.m0_readData_valid  = in_rd_data_s & ~grant_r & bus.s_readData_valid;
  assign bus.m1_readData_valid  = in_rd_data_s &  grant_r & bus.s_readData_valid;
  assign bus.m0_writeAddr_ready = in_wr_addr_s & ~grant_r & bus.s_writeAddr_ready;
  assign bus.m1_writeAddr_ready = in_wr_addr_s &  grant_r & bus.s_writeAddr_ready;
  assign bus.m0_writeData_ready = in_wr_addr_s & ~grant_r & bus.s_writeData_ready;
  assign bus.m1_writeData_ready = in_wr_addr_s &  grant_r & bus.s_writeData_ready;
  assign bus.m0_writeResp_valid = in_wr_resp_s & ~grant_r & bus.s_writeResp_valid;
  assign bus.m1_writeResp_valid = in_wr_resp_s &  grant_r & bus.s_writeResp_valid;

  // Shared return buses are broadcast; the per-master valids qualify them.
  assign bus.m_readData      = bus.s_readData;
  assign bus.m_writeResp_msg = bus.s_writeResp_msg;

endmodule
